// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the memory access controller.
// Revision    : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_access  = 2'd1;
    localparam logic [1:0] c_st_release = 2'd2;
    localparam logic [1:0] c_st_fault   = 2'd3;

    // Code 3 is reserved and never produced.
    localparam logic [1:0] c_fault_none    = 2'd0;
    localparam logic [1:0] c_fault_ana     = 2'd1;
    localparam logic [1:0] c_fault_timeout = 2'd2;

    localparam logic c_own_fetch = 1'b0;
    localparam logic c_own_data  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_counter
// Description : 8-bit saturating cycle counter with terminal-count flag.
// Revision    : 1.0
// ============================================================================
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] c_terminal = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign terminal = (r_count == c_terminal);

endmodule
`default_nettype wire

// File: rtl/memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_controller
// Description : Arbitrates fetch/data requests onto the single memory port.
// Revision    : 1.0
// ============================================================================
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_req,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_done,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_mfc,
    input  logic                  mem_ana_flag,
    input  logic                  fault_clear,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic                  busy
);

    logic [1:0]            r_state;
    logic                  r_owner;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_fetch_done;
    logic                  r_data_done;
    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic [DATA_WIDTH-1:0] r_data_rdata;
    logic                  r_fault;
    logic [1:0]            r_fault_code;
    logic                  r_busy;

    logic w_in_access;
    logic w_cnt_clear;
    logic w_terminal;
    logic w_finish;
    logic w_capture;

    assign w_in_access = (r_state == c_st_access);
    assign w_cnt_clear = (r_state == c_st_idle);
    // Any ACCESS exit (fault, completion or timeout) ends the strobe and pulses Done.
    assign w_finish    = w_in_access && (mem_ana_flag || mem_mfc || w_terminal);
    assign w_capture   = w_in_access && !mem_ana_flag && mem_mfc && !r_write;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_cnt_clear),
        .enable  (w_in_access),
        .terminal(w_terminal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_owner      <= c_own_fetch;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_fetch_data <= '0;
            r_data_rdata <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= c_fault_none;
            r_busy       <= 1'b0;
        end else begin
            r_fetch_done <= w_finish && (r_owner == c_own_fetch);
            r_data_done  <= w_finish && (r_owner == c_own_data);
            if (w_capture && (r_owner == c_own_fetch)) r_fetch_data <= mem_data_out;
            if (w_capture && (r_owner == c_own_data))  r_data_rdata <= mem_data_out;
            if (w_finish) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (data_req || fetch_req) begin
                        r_owner     <= data_req ? c_own_data : c_own_fetch;
                        r_write     <= data_req && data_write;
                        r_addr      <= data_req ? data_addr : fetch_addr;
                        r_wdata     <= data_req ? data_wdata : '0;
                        r_mem_read  <= !(data_req && data_write);
                        r_mem_write <= data_req && data_write;
                        r_busy      <= 1'b1;
                        r_state     <= c_st_access;
                    end
                end
                c_st_access: begin
                    if (mem_ana_flag) begin
                        r_fault      <= 1'b1;
                        r_fault_code <= c_fault_ana;
                        r_state      <= c_st_fault;
                    end else if (mem_mfc) begin
                        r_state <= c_st_release;
                    end else if (w_terminal) begin
                        r_fault      <= 1'b1;
                        r_fault_code <= c_fault_timeout;
                        r_state      <= c_st_fault;
                    end
                end
                c_st_release: begin
                    if (!mem_mfc) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                c_st_fault: begin
                    if (fault_clear) begin
                        r_fault      <= 1'b0;
                        r_fault_code <= c_fault_none;
                        r_busy       <= 1'b0;
                        r_state      <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign fetch_done  = r_fetch_done;
    assign fetch_data  = r_fetch_data;
    assign data_done   = r_data_done;
    assign data_rdata  = r_data_rdata;
    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_controller
// Description : Directed self-checking bench for memory_access_controller.
// Revision    : 1.0
// ============================================================================
module tb_memory_access_controller;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_done;
    logic [DW-1:0] fetch_data;
    logic          data_req = 1'b0;
    logic          data_write = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_done;
    logic [DW-1:0] data_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_data_out = '0;
    logic          mem_mfc = 1'b0;
    logic          mem_ana_flag = 1'b0;
    logic          fault_clear = 1'b0;
    logic          fault;
    logic [1:0]    fault_code;
    logic          busy;

    memory_access_controller #(
        .TIMEOUT_CYCLES(16),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_done  (fetch_done),
        .fetch_data  (fetch_data),
        .data_req    (data_req),
        .data_write  (data_write),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_done   (data_done),
        .data_rdata  (data_rdata),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_data_out(mem_data_out),
        .mem_mfc     (mem_mfc),
        .mem_ana_flag(mem_ana_flag),
        .fault_clear (fault_clear),
        .fault       (fault),
        .fault_code  (fault_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Per-cycle event tallies, sampled on the edge before outputs change.
    int n_rd = 0, n_wr = 0, n_fd = 0, n_dd = 0;
    always @(posedge clk) begin
        if (mem_read)   n_rd++;
        if (mem_write)  n_wr++;
        if (fetch_done) n_fd++;
        if (data_done)  n_dd++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b_rd, b_wr, b_fd, b_dd;
    task automatic snap();
        b_rd = n_rd; b_wr = n_wr; b_fd = n_fd; b_dd = n_dd;
    endtask

    initial begin
        // Reset state
        ticks(3);
        check_eq("rst_read", mem_read, 0);
        check_eq("rst_write", mem_write, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fault", {fault, fault_code}, 0);
        check_eq("rst_data", {fetch_data, data_rdata}, 0);
        check_eq("rst_done", {fetch_done, data_done}, 0);
        rst = 1'b0;
        ticks(1);

        // Fetch with MFC on the second ACCESS cycle
        snap();
        fetch_req = 1'b1; fetch_addr = 32'h10;
        ticks(1);
        check_eq("f1_read", mem_read, 1);
        check_eq("f1_addr", mem_address, 32'h10);
        check_eq("f1_busy", busy, 1);
        ticks(1);
        mem_mfc = 1'b1; mem_data_out = 32'hDEADBEEF;
        ticks(1);
        check_eq("f1_done", fetch_done, 1);
        check_eq("f1_data", fetch_data, 32'hDEADBEEF);
        check_eq("f1_read_off", mem_read, 0);
        fetch_req = 1'b0; mem_mfc = 1'b0;
        ticks(1);
        check_eq("f1_idle", busy, 0);
        check_eq("f1_rd_cycles", n_rd - b_rd, 2);
        check_eq("f1_wr_cycles", n_wr - b_wr, 0);
        check_eq("f1_done_cnt", n_fd - b_fd, 1);

        // Store, MFC held 3 extra cycles keeps RELEASE and blocks a new grant
        snap();
        data_req = 1'b1; data_write = 1'b1; data_addr = 32'h20; data_wdata = 32'h1234;
        ticks(1);
        check_eq("st_write", mem_write, 1);
        check_eq("st_read", mem_read, 0);
        check_eq("st_addr", mem_address, 32'h20);
        check_eq("st_wdata", mem_data_in, 32'h1234);
        mem_mfc = 1'b1; mem_data_out = 32'hFFFF0000;
        ticks(1);
        check_eq("st_done", data_done, 1);
        check_eq("st_write_off", mem_write, 0);
        data_req = 1'b0; data_write = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h44;
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            check_eq("st_release_busy", busy, 1);
            check_eq("st_release_strobe", {mem_read, mem_write}, 0);
        end
        check_eq("st_done_cnt", n_dd - b_dd, 1);
        mem_mfc = 1'b0;
        ticks(1);
        check_eq("st_back_idle", busy, 0);
        ticks(1);
        check_eq("st_then_fetch", mem_read, 1);
        check_eq("st_then_addr", mem_address, 32'h44);
        mem_mfc = 1'b1; mem_data_out = 32'h0BAD;
        ticks(1);
        check_eq("st_then_done", fetch_done, 1);
        check_eq("st_rdata_kept", data_rdata, 0);
        fetch_req = 1'b0; mem_mfc = 1'b0;
        ticks(1);

        // Simultaneous requests: data first
        snap();
        fetch_req = 1'b1; fetch_addr = 32'h40;
        data_req = 1'b1; data_addr = 32'h30;
        ticks(1);
        check_eq("pr_data_first", mem_address, 32'h30);
        check_eq("pr_read", mem_read, 1);
        mem_mfc = 1'b1; mem_data_out = 32'hA5A5;
        ticks(1);
        check_eq("pr_ddone", {fetch_done, data_done}, 2'b01);
        check_eq("pr_rdata", data_rdata, 32'hA5A5);
        data_req = 1'b0; mem_mfc = 1'b0;
        ticks(1);
        check_eq("pr_gap", mem_read, 0);
        ticks(1);
        check_eq("pr_fetch_addr", mem_address, 32'h40);
        check_eq("pr_fetch_read", mem_read, 1);
        mem_mfc = 1'b1; mem_data_out = 32'h5555;
        ticks(1);
        check_eq("pr_fdone", {fetch_done, data_done}, 2'b10);
        check_eq("pr_fdata", fetch_data, 32'h5555);
        fetch_req = 1'b0; mem_mfc = 1'b0;
        ticks(1);
        check_eq("pr_fd_cnt", n_fd - b_fd, 1);
        check_eq("pr_dd_cnt", n_dd - b_dd, 1);

        // Address fault beats MFC; pending fetch waits for Fault_Clear
        snap();
        data_req = 1'b1; data_addr = 32'h50; fetch_req = 1'b1;
        ticks(1);
        mem_mfc = 1'b1; mem_ana_flag = 1'b1; mem_data_out = 32'h9999;
        ticks(1);
        check_eq("ana_fault", {fault, fault_code}, 3'b101);
        check_eq("ana_done", data_done, 1);
        check_eq("ana_no_capture", data_rdata, 32'hA5A5);
        data_req = 1'b0; mem_mfc = 1'b0; mem_ana_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            check_eq("ana_hold", {fault, busy, mem_read, data_done}, 4'b1100);
        end
        check_eq("ana_dd_cnt", n_dd - b_dd, 1);
        fault_clear = 1'b1;
        ticks(1);
        fault_clear = 1'b0;
        check_eq("ana_cleared", {fault, fault_code, busy}, 0);
        ticks(1);
        check_eq("ana_fetch_grant", mem_read, 1);
        check_eq("ana_fetch_addr", mem_address, 32'h40);
        mem_mfc = 1'b1; mem_data_out = 32'h7777;
        ticks(1);
        check_eq("ana_fetch_done", fetch_done, 1);
        fetch_req = 1'b0; mem_mfc = 1'b0;
        ticks(1);

        // Fault_Clear outside FAULT is ignored
        fault_clear = 1'b1;
        ticks(1);
        fault_clear = 1'b0;
        check_eq("fc_idle_noeffect", {fault, busy}, 0);

        // Timeout with no MFC
        snap();
        fetch_req = 1'b1; fetch_addr = 32'h60;
        for (int i = 0; i < 40 && !fault; i++) ticks(1);
        check_eq("to_fault", fault, 1);
        check_eq("to_code", fault_code, 2);
        check_eq("to_done", fetch_done, 1);
        check_eq("to_rd_cycles", n_rd - b_rd, 16);
        fetch_req = 1'b0;
        fault_clear = 1'b1;
        ticks(1);
        fault_clear = 1'b0;
        check_eq("to_cleared", {fault, fault_code}, 0);

        // Reset in ACCESS cycle 3
        data_req = 1'b1; data_write = 1'b0; data_addr = 32'h70;
        ticks(3);
        check_eq("rs_pre_read", mem_read, 1);
        snap();
        rst = 1'b1;
        #1;
        check_eq("rs_async_read", mem_read, 0);
        check_eq("rs_async_busy", busy, 0);
        ticks(1);
        rst = 1'b0;
        check_eq("rs_no_done", n_dd - b_dd, 0);
        ticks(1);
        check_eq("rs_regrant", mem_read, 1);
        check_eq("rs_regrant_addr", mem_address, 32'h70);
        mem_mfc = 1'b1; mem_data_out = 32'hCAFE;
        ticks(1);
        check_eq("rs_done", data_done, 1);
        check_eq("rs_rdata", data_rdata, 32'hCAFE);
        data_req = 1'b0; mem_mfc = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Owns the single external memory port (MEM_* bus) of the multi-cycle processor.
- Arbitrates between instruction-fetch requests (IR load, address from PC) and data load/store requests (address from RZ, write data from RM).
- Sequences each access through a MEM_MFC handshake with timeout and address-fault detection, and returns the read data plus a one-cycle completion pulse to the requester.
- Sits between the control signal generator/datapath and the memory subsystem, replacing direct strobe generation.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for MEM_MFC before a timeout fault (legal range 2..255).
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, word-address width.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Fetch_Req  in  1  level request for an instruction read; held until Fetch_Done
- Fetch_Addr  in  ADDR_WIDTH  fetch word address (PC)
- Fetch_Done  out  1  one-cycle completion pulse for fetch
- Fetch_Data  out  DATA_WIDTH  fetched word; valid while Fetch_Done=1, held until next capture
- Data_Req  in  1  level request for a data access; held until Data_Done
- Data_Write  in  1  1=store, 0=load; sampled at grant
- Data_Addr  in  ADDR_WIDTH  data word address (RZ)
- Data_Wdata  in  DATA_WIDTH  store data (RM)
- Data_Done  out  1  one-cycle completion pulse for data access
- Data_Rdata  out  DATA_WIDTH  loaded word; valid while Data_Done=1
- MEM_Address  out  ADDR_WIDTH  memory address
- MEM_Data_In  out  DATA_WIDTH  memory write data
- MEM_Read  out  1  read strobe
- MEM_Write  out  1  write strobe
- MEM_Data_Out  in  DATA_WIDTH  memory read data
- MEM_MFC  in  1  memory function complete
- MEM_ANA_FLAG  in  1  address not assigned
- Fault_Clear  in  1  releases FAULT state
- Fault  out  1  sticky fault indicator
- Fault_Code  out  2  0=none, 1=address not assigned, 2=timeout, 3=reserved
- Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE and the timeout counter clears.
  - All outputs go to 0, including MEM_Read, MEM_Write, both Done pulses, both data outputs, Fault and Fault_Code.
  - Reset mid-access drops the strobes immediately; no Done pulse is issued for the aborted access.
- All outputs are registered.
- States: IDLE, ACCESS, RELEASE, FAULT.
- IDLE:
  - If Data_Req=1, grant data. Otherwise, if Fetch_Req=1, grant fetch. Data has fixed priority.
  - On grant, latch address, write data, direction and grant owner, then go to ACCESS.
  - Input changes after grant are ignored until the next IDLE.
- ACCESS:
  - MEM_Read = ~write, MEM_Write = write; MEM_Address and MEM_Data_In come from the latches.
  - The counter increments every ACCESS cycle.
- ACCESS exits, evaluated per cycle in priority order:
  - MEM_ANA_FLAG=1: Fault_Code=1 and go to FAULT. This applies even if MEM_MFC=1 in the same cycle.
  - Else MEM_MFC=1: capture MEM_Data_Out into the owner's data output (loads and fetches only), pulse the owner's Done next cycle, go to RELEASE.
  - Else counter = TIMEOUT_CYCLES-1: Fault_Code=2 and go to FAULT.
- RELEASE:
  - Strobes are 0.
  - Wait until MEM_MFC=0, then go to IDLE.
  - A new grant is possible on the cycle after returning to IDLE.
- FAULT:
  - Strobes are 0 and Fault=1.
  - The owner's Done pulses once on entry, so the sequencer never hangs.
  - No grants are issued while in FAULT.
  - Fault_Clear=1 returns to IDLE and clears Fault and Fault_Code.
- Latency:
  - Request sampled in IDLE at cycle t, strobe asserted at t+1.
  - MFC sampled at cycle m, Done at m+1.
  - Minimum access is 3 cycles (t, t+1, t+2).
- Simultaneous Fetch_Req and Data_Req: data is served first; the fetch is served after RELEASE→IDLE if still requested.
- Fault_Clear outside FAULT has no effect.
- The counter is 8 bits wide, saturates, and is cleared on entry to ACCESS.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state encoding (IDLE=0, ACCESS=1, RELEASE=2, FAULT=3)
  - fault code constants
  - owner constants (OWN_FETCH=0, OWN_DATA=1)
- One sub-module: mem_timeout_counter (clear, enable, terminal-count output; parameter TIMEOUT_CYCLES).

Test Plan:
- Fetch, Fetch_Addr=0x10, memory returns MFC at 2nd ACCESS cycle with 0xDEADBEEF → MEM_Read high for 2 cycles, MEM_Address=0x10, Fetch_Done one pulse with Fetch_Data=0xDEADBEEF, MEM_Write never high.
- Store Data_Addr=0x20, Data_Wdata=0x1234 → MEM_Write=1, MEM_Data_In=0x1234, MEM_Read=0; Data_Done pulses; MFC held high 3 extra cycles → stays in RELEASE, no new grant until MFC=0.
- Fetch_Req and Data_Req asserted same cycle → data access issued first, fetch strobe starts after RELEASE completes; exactly one Done per requester.
- MEM_ANA_FLAG=1 with MEM_MFC=1 on load → Fault=1, Fault_Code=1, Data_Done one pulse; pending Fetch_Req not granted until Fault_Clear, then granted.
- No MFC with TIMEOUT_CYCLES=16 → strobe high exactly 16 cycles, Fault_Code=2, Fetch_Done one pulse.
- Reset asserted in ACCESS cycle 3 → MEM_Read drops asynchronously, no Done, Busy=0; request still high after reset release → fresh grant next cycle.
